// File: rtl/uart_tx_frame_pkg.sv
// Shared types and default sizing for the parametrised UART frame transmitter.
package uart_tx_frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam int unsigned DEF_DWIDTH       = 6;
  localparam int unsigned DEF_CLKS_PER_BIT = 5;
  localparam int unsigned DEF_STOP_BITS    = 1;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts while en is high, clears when low, ticks on the last cycle of a bit.
module uart_baud_cnt #(
  parameter int unsigned CLKS_PER_BIT = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic bit_tick
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d    = '0;
    bit_tick = 1'b0;
    if (en) begin
      if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
        bit_tick = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start, DWIDTH data bits LSB-first, optional parity, STOP_BITS stops.
// Parity support is built only when UART_TX_PARITY_EN is defined.
module uart_tx_frame
  import uart_tx_frame_pkg::*;
#(
  parameter int unsigned DWIDTH       = DEF_DWIDTH,
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int unsigned STOP_BITS    = DEF_STOP_BITS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_valid_i,
  input  logic [DWIDTH-1:0] tx_data_i,
  output logic              tx_ready_o,
  input  logic              par_en_i,
  input  logic              par_odd_i,
  output logic              tx_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int unsigned IDX_W = $clog2(DWIDTH + 1);

  tx_state_e         state_q, state_d;
  logic [DWIDTH-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              stop_q, stop_d;
  logic              tx_q, tx_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              bit_tick_c;
  logic              accept_c;
  logic              par_take_c;
  logic              par_bit_c;

  assign accept_c = tx_valid_i && ready_q;

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (state_q != IDLE),
    .bit_tick(bit_tick_c)
  );

`ifdef UART_TX_PARITY_EN
  logic par_en_q, par_en_d;
  logic par_bit_q, par_bit_d;

  // Parity settings are frozen at acceptance along with the data word.
  always_comb begin
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    if (accept_c) begin
      par_en_d  = par_en_i;
      par_bit_d = (^tx_data_i) ^ par_odd_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
    end
  end

  assign par_take_c = par_en_q;
  assign par_bit_c  = par_bit_q;
`else
  logic unused_par_c;
  assign unused_par_c = par_en_i ^ par_odd_i;
  assign par_take_c   = 1'b0;
  assign par_bit_c    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    tx_d    = tx_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d = START;
          shift_d = tx_data_i;
          idx_d   = '0;
          stop_d  = 1'b0;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bit_tick_c) begin
          state_d = DATA;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          idx_d   = IDX_W'(1);
        end
      end
      // idx_q counts data bits already placed on the line.
      DATA: begin
        if (bit_tick_c) begin
          if (idx_q == IDX_W'(DWIDTH)) begin
            if (par_take_c) begin
              state_d = PARITY;
              tx_d    = par_bit_c;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
              stop_d  = 1'b0;
            end
          end else begin
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
            idx_d   = idx_q + IDX_W'(1);
          end
        end
      end
      PARITY: begin
        if (bit_tick_c) begin
          state_d = STOP;
          tx_d    = 1'b1;
          stop_d  = 1'b0;
        end
      end
      STOP: begin
        if (bit_tick_c) begin
          if (stop_q == 1'(STOP_BITS - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            stop_d = 1'b1;
          end
          tx_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx_o       = tx_q;
  assign tx_ready_o = ready_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: a frame-level model checks two instances (1 and 2 stop bits) every cycle.
module tb_uart_tx_frame;

  localparam int DW  = 6;
  localparam int CPB = 5;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_BUILT = 1'b1;
`else
  localparam bit PAR_BUILT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          par_en, par_odd;
  logic          a_valid, b_valid;
  logic [DW-1:0] a_data, b_data;
  logic          a_ready, a_tx, a_busy, a_done;
  logic          b_ready, b_tx, b_busy, b_done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  uart_tx_frame #(.DWIDTH(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .tx_valid_i(a_valid), .tx_data_i(a_data),
    .tx_ready_o(a_ready), .par_en_i(par_en), .par_odd_i(par_odd),
    .tx_o(a_tx), .busy_o(a_busy), .done_o(a_done)
  );

  uart_tx_frame #(.DWIDTH(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .tx_valid_i(b_valid), .tx_data_i(b_data),
    .tx_ready_o(b_ready), .par_en_i(par_en), .par_odd_i(par_odd),
    .tx_o(b_tx), .busy_o(b_busy), .done_o(b_done)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a frame is a bit list; cycle k after acceptance shows bit (k-1)/CPB.
  bit          m_active[2];
  int          m_k[2];
  logic [31:0] m_bits[2];
  int          m_nb[2];
  bit          acc_pending[2];

  task automatic model_step(input int d, input logic v, input logic [DW-1:0] data,
                            input logic tx, input logic rdy, input logic bsy, input logic dn);
    logic        etx, erdy, ebsy, edn;
    int          flen, n;
    logic [31:0] b;
    etx = 1'b1; erdy = 1'b1; ebsy = 1'b0; edn = 1'b0;
    if (!rst_n) begin
      m_active[d]    = 1'b0;
      acc_pending[d] = 1'b0;
    end else begin
      if (m_active[d]) begin
        m_k[d]++;
        flen = m_nb[d] * CPB;
        if (m_k[d] <= flen) begin
          etx  = m_bits[d][(m_k[d] - 1) / CPB];
          erdy = 1'b0;
          ebsy = 1'b1;
        end else if (m_k[d] == flen + 1) begin
          edn = 1'b1;
        end else begin
          m_active[d] = 1'b0;
        end
      end
      acc_pending[d] = v && erdy;
      if (acc_pending[d]) begin
        b = '0;
        n = 1;
        for (int i = 0; i < DW; i++) begin
          b[n] = data[i];
          n++;
        end
        if (PAR_BUILT && par_en) begin
          b[n] = (^data) ^ par_odd;
          n++;
        end
        for (int s = 0; s < d + 1; s++) begin
          b[n] = 1'b1;
          n++;
        end
        m_bits[d]   = b;
        m_nb[d]     = n;
        m_k[d]      = 0;
        m_active[d] = 1'b1;
      end
    end
    chk($sformatf("tx_o[%0d]", d), tx, etx);
    chk($sformatf("tx_ready_o[%0d]", d), rdy, erdy);
    chk($sformatf("busy_o[%0d]", d), bsy, ebsy);
    chk($sformatf("done_o[%0d]", d), dn, edn);
  endtask

  always @(negedge clk) begin
    model_step(0, a_valid, a_data, a_tx, a_ready, a_busy, a_done);
    model_step(1, b_valid, b_data, b_tx, b_ready, b_busy, b_done);
  end

  // Waits for the edge at which the model predicts acceptance; returns edges waited.
  task automatic wait_acc(input int d, output int cnt);
    bit ok;
    ok  = 1'b0;
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      cnt++;
      if (acc_pending[d]) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    chk("accept_seen", 32'(ok), 32'd1);
  endtask

  task automatic run_frame(input int d, input logic [DW-1:0] data, input logic pe, input logic po,
                           output int done_at, output logic [63:0] txs);
    int cnt;
    par_en  = pe;
    par_odd = po;
    if (d == 0) begin a_data = data; a_valid = 1'b1; end
    else        begin b_data = data; b_valid = 1'b1; end
    wait_acc(d, cnt);
    a_valid = 1'b0;
    b_valid = 1'b0;
    done_at = 0;
    txs     = '0;
    for (int c = 1; c < 60; c++) begin
      @(negedge clk);
      txs[c] = (d == 0) ? a_tx : b_tx;
      if (((d == 0) ? a_done : b_done) && done_at == 0) done_at = c;
    end
  endtask

  initial begin
    int          dn, cnt, tot;
    logic [63:0] txs;
    logic [7:0]  lit;

    rst_n = 1'b0; par_en = 1'b0; par_odd = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", a_tx, 1); chk("rst_ready", a_ready, 1);
    chk("rst_busy", a_busy, 0); chk("rst_done", a_done, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Plain frame, LSB first: 0,1,0,1,1,0,1,1
    run_frame(0, 6'b101101, 1'b0, 1'b0, dn, txs);
    lit = 8'b1101_1010;
    for (int b = 0; b < 8; b++) chk($sformatf("t1_bit%0d", b), txs[b*CPB+3], lit[b]);
    chk("t1_done_at", dn, 41);

    // Parity requested: built -> parity bit at cycles 36..40, else a 40-cycle frame
    run_frame(0, 6'b101101, 1'b1, 1'b0, dn, txs);
    chk("t2_even_bit", txs[38], PAR_BUILT ? 0 : 1);
    chk("t2_done_at", dn, PAR_BUILT ? 46 : 41);
    run_frame(0, 6'b101101, 1'b1, 1'b1, dn, txs);
    chk("t2_odd_bit", txs[38], 1);
    chk("t2_odd_stop", txs[43], 1);

    // Back-to-back with valid held
    par_en = 1'b0;
    a_data = 6'h15; a_valid = 1'b1;
    wait_acc(0, cnt);
    a_data = 6'h2A;
    wait_acc(0, cnt);
    a_valid = 1'b0;
    chk("t3_accept_gap", cnt, 41);
    repeat (45) @(posedge clk);
    #1;

    // Reset during data bit 3 (cycles 21..25) of a zero word
    a_data = 6'h00; a_valid = 1'b1;
    wait_acc(0, cnt);
    a_valid = 1'b0;
    repeat (21) @(posedge clk);
    #1;
    chk("t4_pre_tx", a_tx, 0);
    rst_n = 1'b0;
    #1;
    chk("t4_tx", a_tx, 1); chk("t4_busy", a_busy, 0); chk("t4_ready", a_ready, 1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_frame(0, 6'h3F, 1'b0, 1'b0, dn, txs);
    chk("t4_start", txs[3], 0); chk("t4_d5", txs[33], 1);
    chk("t4_done_at", dn, 41);

    // Two stop bits on instance b
    run_frame(1, 6'h00, 1'b0, 1'b0, dn, txs);
    chk("t5_d5", txs[33], 0); chk("t5_stop1", txs[38], 1); chk("t5_stop2", txs[43], 1);
    chk("t5_done_at", dn, 46);

    // Inputs change mid-frame while valid stays high
    par_en = 1'b1; par_odd = 1'b0;
    a_data = 6'b000001; a_valid = 1'b1;
    wait_acc(0, cnt);
    repeat (10) @(posedge clk);
    #1;
    a_data = 6'b111110; par_odd = 1'b1;
    wait_acc(0, cnt);
    tot = cnt + 10;
    a_valid = 1'b0;
    chk("t6_accept_gap", tot, PAR_BUILT ? 46 : 41);
    repeat (50) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
